// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg: shared definitions for the RV32I writeback stage.
//   - WORD_WIDTH / RF_ADDR_WIDTH: datapath and register-address widths,
//     matching the values used by the register file (rv32i_defs).
//   - LD_* : load funct3 encodings understood by the load aligner.
//   - wb_entry_t : packed load-result FIFO entry {valid, rd, data}.
//   - rd_onehot : one-hot decode of a register address for the pending mask.
// -----------------------------------------------------------------------------
package wb_pkg;

    localparam int WORD_WIDTH    = 32;
    localparam int RF_ADDR_WIDTH = 5;
    localparam int NREGS         = 1 << RF_ADDR_WIDTH;

    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;

    typedef struct packed {
        logic                     valid;
        logic [RF_ADDR_WIDTH-1:0] rd;
        logic [WORD_WIDTH-1:0]    data;
    } wb_entry_t;

    function automatic logic [NREGS-1:0] rd_onehot(input logic [RF_ADDR_WIDTH-1:0] rd);
        logic [NREGS-1:0] one;
        one = {{(NREGS-1){1'b0}}, 1'b1};
        return one << rd;
    endfunction

endpackage

// File: rtl/wb_load_align.sv
// -----------------------------------------------------------------------------
// wb_load_align: combinational load-data aligner / extender.
// Configuration macro: WB_LOAD_ALIGN_EN
//   defined   -> byte/halfword selected by i_byte_off and sign/zero-extended
//                according to i_funct3 (LB/LH/LBU/LHU); every other code
//                passes the word through.
//   undefined -> i_data passes through unchanged; funct3/byte_off unused.
// Ports:
//   i_data     in  WORD_WIDTH  raw word read from memory
//   i_funct3   in  3           load type
//   i_byte_off in  2           address bits [1:0]
//   o_data     out WORD_WIDTH  aligned, extended word
// -----------------------------------------------------------------------------
module wb_load_align
    import wb_pkg::*;
(
    input  logic [WORD_WIDTH-1:0] i_data,
    input  logic [2:0]            i_funct3,
    input  logic [1:0]            i_byte_off,
    output logic [WORD_WIDTH-1:0] o_data
);

`ifdef WB_LOAD_ALIGN_EN
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Select the addressed byte and halfword lanes.
    always_comb begin
        w_byte = 8'h00;
        case (i_byte_off)
            2'd0:    w_byte = i_data[7:0];
            2'd1:    w_byte = i_data[15:8];
            2'd2:    w_byte = i_data[23:16];
            2'd3:    w_byte = i_data[31:24];
            default: w_byte = 8'h00;
        endcase
        // Halfword loads are naturally aligned, so only off[1] matters.
        if (i_byte_off[1]) begin
            w_half = i_data[31:16];
        end else begin
            w_half = i_data[15:0];
        end
    end

    // Extend the selected lane according to the load type.
    always_comb begin
        o_data = i_data;
        case (i_funct3)
            LD_LB:   o_data = {{(WORD_WIDTH-8){w_byte[7]}}, w_byte};
            LD_LH:   o_data = {{(WORD_WIDTH-16){w_half[15]}}, w_half};
            LD_LBU:  o_data = {{(WORD_WIDTH-8){1'b0}}, w_byte};
            LD_LHU:  o_data = {{(WORD_WIDTH-16){1'b0}}, w_half};
            default: o_data = i_data;
        endcase
    end
`else
    logic w_unused_align;

    // Alignment disabled: the word is stored exactly as read.
    assign o_data         = i_data;
    assign w_unused_align = ^{i_funct3, i_byte_off};
`endif

endmodule

// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage: RV32I writeback stage.
// Merges single-cycle ALU results with load results and drives the register
// file's single write port from registered outputs. Load results wait in a
// small inline FIFO while the port is taken by the ALU. An ALU write squashes
// (invalidates) every queued load with the same destination, since the ALU
// instruction is younger. A pending-register mask tells the hazard logic
// which registers still have a write in flight.
// Configuration macro: WB_LOAD_ALIGN_EN (see wb_load_align).
// Parameters:
//   FIFO_DEPTH  load FIFO entries, power of two, >= 2
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   alu_valid/alu_rd/alu_data  ALU result channel (no backpressure)
//   ld_valid/ld_ready          load result handshake
//   ld_rd/ld_data/ld_funct3/ld_byte_off  load result payload
//   wb_we/wb_addr/wb_data      register file write port (registered)
//   pend_mask                  registers with a queued or in-progress write
//   fifo_count                 FIFO occupancy
// -----------------------------------------------------------------------------
module wb_stage
    import wb_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         alu_valid,
    input  logic [RF_ADDR_WIDTH-1:0]     alu_rd,
    input  logic [WORD_WIDTH-1:0]        alu_data,
    input  logic                         ld_valid,
    output logic                         ld_ready,
    input  logic [RF_ADDR_WIDTH-1:0]     ld_rd,
    input  logic [WORD_WIDTH-1:0]        ld_data,
    input  logic [2:0]                   ld_funct3,
    input  logic [1:0]                   ld_byte_off,
    output logic                         wb_we,
    output logic [RF_ADDR_WIDTH-1:0]     wb_addr,
    output logic [WORD_WIDTH-1:0]        wb_data,
    output logic [NREGS-1:0]             pend_mask,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    wb_entry_t                r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]         r_wr_ptr;
    logic [PTR_W-1:0]         r_rd_ptr;
    logic [CNT_W-1:0]         r_count;
    logic                     r_wb_we;
    logic [RF_ADDR_WIDTH-1:0] r_wb_addr;
    logic [WORD_WIDTH-1:0]    r_wb_data;

    logic                     w_full;
    logic                     w_empty;
    logic                     w_alu_wr;
    logic                     w_push;
    logic                     w_push_valid;
    logic                     w_pop;
    wb_entry_t                w_head;
    logic [WORD_WIDTH-1:0]    w_ld_aligned;
    logic [NREGS-1:0]         w_pend;

    wb_load_align u_align (
        .i_data     (ld_data),
        .i_funct3   (ld_funct3),
        .i_byte_off (ld_byte_off),
        .o_data     (w_ld_aligned)
    );

    assign w_full   = (r_count == FULL_CNT);
    assign w_empty  = (r_count == {CNT_W{1'b0}});
    assign w_head   = r_fifo[r_rd_ptr];

    // Readiness depends only on stored occupancy, never on a same-cycle pop,
    // and is forced low while reset is held.
    assign ld_ready = rst_n & ~w_full;

    assign w_alu_wr = alu_valid & (alu_rd != {RF_ADDR_WIDTH{1'b0}});
    // Loads to x0 complete the handshake but never occupy a slot.
    assign w_push   = ld_valid & ld_ready & (ld_rd != {RF_ADDR_WIDTH{1'b0}});
    // A same-cycle load to the ALU's rd is older, so it is born squashed.
    assign w_push_valid = ~(w_alu_wr & (ld_rd == alu_rd));
    // The ALU owns the write port whenever it writes a real register.
    assign w_pop    = ~w_alu_wr & ~w_empty;

    // Pending mask: every valid queued entry plus the write on the port now.
    // Slots outside the occupied range always hold valid=0.
    always_comb begin
        w_pend = {NREGS{1'b0}};
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (r_fifo[i].valid) begin
                w_pend = w_pend | rd_onehot(r_fifo[i].rd);
            end else begin
                w_pend = w_pend;
            end
        end
        if (r_wb_we) begin
            w_pend = w_pend | rd_onehot(r_wb_addr);
        end else begin
            w_pend = w_pend;
        end
    end

    // FIFO storage: squash, pop-invalidate and push of entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo[i] <= '0;
            end
        end else begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (w_alu_wr && (r_fifo[i].rd == alu_rd)) begin
                    r_fifo[i].valid <= 1'b0;
                end
            end
            // Freed slots are cleared so the mask can scan all slots.
            if (w_pop) begin
                r_fifo[r_rd_ptr].valid <= 1'b0;
            end
            if (w_push) begin
                r_fifo[r_wr_ptr] <= '{valid: w_push_valid, rd: ld_rd, data: w_ld_aligned};
            end
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
                2'b01:   r_count <= r_count - {{(CNT_W-1){1'b0}}, 1'b1};
                default: r_count <= r_count;
            endcase
        end
    end

    // Register-file write port: ALU first, then the FIFO head, else idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_we   <= 1'b0;
            r_wb_addr <= {RF_ADDR_WIDTH{1'b0}};
            r_wb_data <= {WORD_WIDTH{1'b0}};
        end else if (w_alu_wr) begin
            r_wb_we   <= 1'b1;
            r_wb_addr <= alu_rd;
            r_wb_data <= alu_data;
        end else if (w_pop) begin
            // A squashed head still drains its slot but writes nothing.
            r_wb_we   <= w_head.valid;
            r_wb_addr <= w_head.rd;
            r_wb_data <= w_head.data;
        end else begin
            r_wb_we   <= 1'b0;
        end
    end

    assign wb_we      = r_wb_we;
    assign wb_addr    = r_wb_addr;
    assign wb_data    = r_wb_data;
    assign pend_mask  = w_pend;
    assign fifo_count = r_count;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;
    import wb_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_byte_off;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] pend_mask;
    logic [1:0]  fifo_count;

    int n_checks;
    int n_errors;

    wb_stage #(.FIFO_DEPTH(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_rd       (ld_rd),
        .ld_data     (ld_data),
        .ld_funct3   (ld_funct3),
        .ld_byte_off (ld_byte_off),
        .wb_we       (wb_we),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .pend_mask   (pend_mask),
        .fifo_count  (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        alu_v;
        logic [4:0]  alu_rd;
        logic [31:0] alu_d;
        logic        ld_v;
        logic [4:0]  ld_rd;
        logic [31:0] ld_d;
        logic [2:0]  f3;
        logic [1:0]  off;
        int          lat;
        logic        exp_we;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[10];

    function automatic vec_t mk(logic av, logic [4:0] ard, logic [31:0] ad,
                                logic lv, logic [4:0] lrd, logic [31:0] ld,
                                logic [2:0] f3, logic [1:0] off, int lat,
                                logic ewe, logic [4:0] eaddr, logic [31:0] edata);
        vec_t v;
        v.alu_v = av; v.alu_rd = ard; v.alu_d = ad;
        v.ld_v = lv; v.ld_rd = lrd; v.ld_d = ld; v.f3 = f3; v.off = off;
        v.lat = lat; v.exp_we = ewe; v.exp_addr = eaddr; v.exp_data = edata;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'h0;
        ld_valid = 1'b0; ld_rd = 5'd0; ld_data = 32'h0;
        ld_funct3 = LD_LW; ld_byte_off = 2'd0;
    endtask

    task automatic drive_alu(input logic [4:0] rd, input logic [31:0] d);
        alu_valid = 1'b1; alu_rd = rd; alu_data = d;
    endtask

    task automatic drive_ld(input logic [4:0] rd, input logic [31:0] d);
        ld_valid = 1'b1; ld_rd = rd; ld_data = d; ld_funct3 = LD_LW; ld_byte_off = 2'd0;
    endtask

    logic [31:0] exp_lb3, exp_lbu1, exp_lh2, exp_lhu0;

    initial begin
        n_checks = 0;
        n_errors = 0;
        idle_inputs();
        rst_n = 1'b0;

`ifdef WB_LOAD_ALIGN_EN
        exp_lb3 = 32'hFFFFFF80; exp_lbu1 = 32'h0000007F;
        exp_lh2 = 32'hFFFF80FF; exp_lhu0 = 32'h00007F01;
`else
        exp_lb3 = 32'h80FF7F01; exp_lbu1 = 32'h80FF7F01;
        exp_lh2 = 32'h80FF7F01; exp_lhu0 = 32'h80FF7F01;
`endif

        vecs[0] = mk(1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0, 32'h0, LD_LW, 2'd0, 1, 1'b1, 5'd5, 32'hDEADBEEF);
        vecs[1] = mk(1'b1, 5'd0,  32'h12345678, 1'b0, 5'd0, 32'h0, LD_LW, 2'd0, 1, 1'b0, 5'd0, 32'h0);
        vecs[2] = mk(1'b1, 5'd31, 32'h00000001, 1'b0, 5'd0, 32'h0, LD_LW, 2'd0, 1, 1'b1, 5'd31, 32'h00000001);
        vecs[3] = mk(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 32'h80FF7F01, LD_LB,  2'd3, 2, 1'b1, 5'd10, exp_lb3);
        vecs[4] = mk(1'b0, 5'd0, 32'h0, 1'b1, 5'd11, 32'h80FF7F01, LD_LBU, 2'd1, 2, 1'b1, 5'd11, exp_lbu1);
        vecs[5] = mk(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'h80FF7F01, LD_LH,  2'd2, 2, 1'b1, 5'd12, exp_lh2);
        vecs[6] = mk(1'b0, 5'd0, 32'h0, 1'b1, 5'd13, 32'h80FF7F01, LD_LHU, 2'd0, 2, 1'b1, 5'd13, exp_lhu0);
        vecs[7] = mk(1'b0, 5'd0, 32'h0, 1'b1, 5'd14, 32'h12345678, LD_LW,  2'd0, 2, 1'b1, 5'd14, 32'h12345678);
        vecs[8] = mk(1'b0, 5'd0, 32'h0, 1'b1, 5'd0,  32'hCAFEF00D, LD_LW,  2'd0, 2, 1'b0, 5'd0, 32'h0);
        // alu_rd==0 does not block the pop of a load accepted the same cycle
        vecs[9] = mk(1'b0, 5'd0, 32'h0, 1'b1, 5'd15, 32'hA5A5A5A5, LD_LW,  2'd0, 2, 1'b1, 5'd15, 32'hA5A5A5A5);

        // ---------------- reset values ----------------
        #2;
        check("rst_wb_we", {31'h0, wb_we}, 32'h0);
        check("rst_wb_addr", {27'h0, wb_addr}, 32'h0);
        check("rst_wb_data", wb_data, 32'h0);
        check("rst_fifo_count", {30'h0, fifo_count}, 32'h0);
        check("rst_pend_mask", pend_mask, 32'h0);
        check("rst_ld_ready", {31'h0, ld_ready}, 32'h0);
        step();
        rst_n = 1'b1;
        #1;
        check("post_rst_ld_ready", {31'h0, ld_ready}, 32'h1);
        step();

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 10; i++) begin
            alu_valid = vecs[i].alu_v; alu_rd = vecs[i].alu_rd; alu_data = vecs[i].alu_d;
            ld_valid = vecs[i].ld_v; ld_rd = vecs[i].ld_rd; ld_data = vecs[i].ld_d;
            ld_funct3 = vecs[i].f3; ld_byte_off = vecs[i].off;
            if (i == 9) begin
                alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFFFFFF;
            end
            step();
            idle_inputs();
            if (i == 9) begin
                alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFFFFFF;
            end
            for (int k = 1; k < vecs[i].lat; k++) step();
            idle_inputs();
            check($sformatf("vec%0d_we", i), {31'h0, wb_we}, {31'h0, vecs[i].exp_we});
            if (vecs[i].exp_we) begin
                check($sformatf("vec%0d_addr", i), {27'h0, wb_addr}, {27'h0, vecs[i].exp_addr});
                check($sformatf("vec%0d_data", i), wb_data, vecs[i].exp_data);
            end
            check($sformatf("vec%0d_count", i), {30'h0, fifo_count}, 32'h0);
        end
        step();
        check("idle_we", {31'h0, wb_we}, 32'h0);
        check("idle_pend", pend_mask, 32'h0);

        // ---------------- backpressure ----------------
        drive_alu(5'd7, 32'h00000077);
        drive_ld(5'd3, 32'h00000033);
        step();
        check("bp_count1", {30'h0, fifo_count}, 32'h1);
        check("bp_ready1", {31'h0, ld_ready}, 32'h1);
        drive_ld(5'd4, 32'h00000044);
        step();
        check("bp_count2", {30'h0, fifo_count}, 32'h2);
        check("bp_ready_full", {31'h0, ld_ready}, 32'h0);
        check("bp_pend", pend_mask, 32'h00000098);
        check("bp_alu_addr", {27'h0, wb_addr}, 32'd7);
        drive_ld(5'd8, 32'h00000088);
        step();
        step();
        check("bp_hold_count", {30'h0, fifo_count}, 32'h2);
        alu_valid = 1'b0;
        // full + pop: the offered rd=8 load must not be taken this cycle
        check("bp_fullpop_ready", {31'h0, ld_ready}, 32'h0);
        step();
        check("bp_pop3_we", {31'h0, wb_we}, 32'h1);
        check("bp_pop3_addr", {27'h0, wb_addr}, 32'd3);
        check("bp_pop3_data", wb_data, 32'h00000033);
        check("bp_after_fullpop_count", {30'h0, fifo_count}, 32'h1);
        step();
        ld_valid = 1'b0;
        check("bp_pop4_addr", {27'h0, wb_addr}, 32'd4);
        check("bp_pop4_data", wb_data, 32'h00000044);
        check("bp_pop4_count", {30'h0, fifo_count}, 32'h1);
        step();
        check("bp_pop8_addr", {27'h0, wb_addr}, 32'd8);
        check("bp_pop8_data", wb_data, 32'h00000088);
        step();
        check("bp_drain_we", {31'h0, wb_we}, 32'h0);
        check("bp_drain_count", {30'h0, fifo_count}, 32'h0);
        check("bp_drain_pend", pend_mask, 32'h0);

        // ---------------- squash ----------------
        drive_ld(5'd9, 32'h00000099);
        step();
        idle_inputs();
        check("sq_pend_queued", pend_mask, 32'h00000200);
        drive_alu(5'd9, 32'h000000A9);
        step();
        idle_inputs();
        check("sq_alu_addr", {27'h0, wb_addr}, 32'd9);
        check("sq_alu_data", wb_data, 32'h000000A9);
        check("sq_slot_held", {30'h0, fifo_count}, 32'h1);
        step();
        check("sq_pop_we", {31'h0, wb_we}, 32'h0);
        check("sq_pop_pend", pend_mask, 32'h0);
        check("sq_pop_count", {30'h0, fifo_count}, 32'h0);

        // ---------------- same-cycle conflict ----------------
        drive_alu(5'd6, 32'h000000A6);
        drive_ld(5'd6, 32'h00000066);
        step();
        idle_inputs();
        check("sc_we", {31'h0, wb_we}, 32'h1);
        check("sc_data", wb_data, 32'h000000A6);
        check("sc_pend", pend_mask, 32'h00000040);
        check("sc_count", {30'h0, fifo_count}, 32'h1);
        step();
        check("sc_pop_we", {31'h0, wb_we}, 32'h0);
        check("sc_pop_count", {30'h0, fifo_count}, 32'h0);

        // ---------------- reset mid-stream ----------------
        drive_alu(5'd7, 32'h00000070);
        drive_ld(5'd3, 32'h00000030);
        step();
        drive_ld(5'd4, 32'h00000040);
        step();
        check("mr_queued", {30'h0, fifo_count}, 32'h2);
        idle_inputs();
        rst_n = 1'b0;
        #1;
        check("mr_we", {31'h0, wb_we}, 32'h0);
        check("mr_count", {30'h0, fifo_count}, 32'h0);
        check("mr_pend", pend_mask, 32'h0);
        check("mr_ready", {31'h0, ld_ready}, 32'h0);
        step();
        rst_n = 1'b1;
        #1;
        check("mr_ready_after", {31'h0, ld_ready}, 32'h1);
        step();
        check("mr_no_write", {31'h0, wb_we}, 32'h0);
        step();
        check("mr_no_write2", {31'h0, wb_we}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
